dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data RAM.
// Each access takes three cycles: grant (IDLE), RAM command (ACCESS), completion (RESP).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [31:0]           m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [31:0]           m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_q;   // 1 = m1 was granted last
  logic              owner_q;  // 1 = m1 owns the transaction in flight
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              any_req;
  logic              win;
  logic              grant;
  logic              access;
  logic              resp;
  logic [DATA_W-1:0] resp_data;

  // Word addressing drops the byte offset and any bits above the RAM size.
  logic unused_addr;
  assign unused_addr = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0], m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  assign any_req = m0_req | m1_req;
  // m1 wins when alone, or on a tie when m0 was granted last.
  assign win     = m1_req & (~m0_req | ~last_q);
  assign grant   = reset & (state_q == StIdle) & any_req;
  assign access  = reset & (state_q == StAccess);
  assign resp    = reset & (state_q == StResp);

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:   state_d = any_req ? StAccess : StIdle;
      StAccess: state_d = StResp;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_q  <= win;
        owner_q <= win;
        we_q    <= win ? m1_we : m0_we;
        addr_q  <= win ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
        wdata_q <= win ? m1_wdata : m0_wdata;
        wstrb_q <= win ? m1_wstrb : m0_wstrb;
      end
    end
  end

  assign m0_gnt    = grant & ~win;
  assign m1_gnt    = grant & win;

  assign mem_en    = access;
  assign mem_we    = access & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = we_q ? wstrb_q : '0;

  assign m0_rvalid = resp & ~owner_q;
  assign m1_rvalid = resp & owner_q;
  assign resp_data = we_q ? '0 : mem_rdata;
  assign m0_rdata  = m0_rvalid ? resp_data : '0;
  assign m1_rdata  = m1_rvalid ? resp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand sequences,
// with a byte-strobed behavioural RAM on the memory port.
module tb_dmem_arbiter;

  localparam logic [31:0] D129 = 32'hA5A5_0129;
  localparam logic [31:0] D130 = 32'h5A5A_0130;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_wstrb  (m0_wstrb),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_wstrb  (m1_wstrb),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;  // bit 0 = m0, bit 1 = m1
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [31:0] q0, q1;
    logic        en, mwe;
    logic [9:0]  ma;
    logic [3:0]  ms;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(
    input int unsigned rst, req, we, a0, a1, d0, d1, s0, s1,
    input int unsigned gnt, rv, q0, q1, en, mwe, ma, ms
  );
    vec_t r;
    r.rst = rst[0];  r.req = req[1:0]; r.we = we[1:0];
    r.a0  = a0;      r.a1  = a1;       r.d0 = d0;      r.d1 = d1;
    r.s0  = s0[3:0]; r.s1  = s1[3:0];
    r.gnt = gnt[1:0]; r.rv = rv[1:0]; r.q0 = q0;       r.q1 = q1;
    r.en  = en[0];   r.mwe = mwe[0];  r.ma = ma[9:0];  r.ms = ms[3:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] <= '0;
    ram[129] <= D129;
    ram[130] <= D130;
    reset = 1'b0;
    idle_inputs();

    // Reset held with requests pending, then release.
    tv.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(0, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    // m0 full write to 0x200, then read it back.
    tv.push_back(v(1, 1, 1, 'h200, 0, 32'hFFFF_FFFC, 0, 'hF, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 128, 'hF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 1, 0, 'h200, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 128, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 32'hFFFF_FFFC, 0,  0, 0, 0, 0));
    // m1 full write, byte write, read back at 0x20C.
    tv.push_back(v(1, 2, 2, 0, 'h20C, 0, 32'h1234_5678, 0, 'hF,  2, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 131, 'hF));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 2, 2, 0, 'h20C, 0, 'hAB, 0, 'h1,  2, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 131, 'h1));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 2, 0, 0, 'h20C, 0, 0, 0, 0,  2, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 131, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 32'h1234_56AB,  0, 0, 0, 0));
    // Both requesters held: grants alternate m0, m1, m0, m1 every 3 cycles.
    for (int k = 0; k < 2; k++) begin
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 129, 0));
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  0, 1, D129, 0,  0, 0, 0, 0));
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  2, 0, 0, 0,  0, 0, 0, 0));
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 130, 0));
      tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  0, 2, 0, D130,  0, 0, 0, 0));
    end
    // Reset during ACCESS of an m0 read aborts it; next tie goes to m0.
    tv.push_back(v(1, 1, 0, 'h204, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 3, 0, 'h204, 'h208, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 2, 0, 0, 'h208, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 129, 0));
    tv.push_back(v(1, 2, 0, 0, 'h208, 0, 0, 0, 0,  0, 1, D129, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 2, 0, 0, 'h208, 0, 0, 0, 0,  2, 0, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 130, 0));
    tv.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, D130,  0, 0, 0, 0));

    tick();
    for (int i = 0; i < tv.size(); i++) begin
      reset    = tv[i].rst;
      m0_req   = tv[i].req[0]; m0_we = tv[i].we[0]; m0_addr = tv[i].a0;
      m0_wdata = tv[i].d0;     m0_wstrb = tv[i].s0;
      m1_req   = tv[i].req[1]; m1_we = tv[i].we[1]; m1_addr = tv[i].a1;
      m1_wdata = tv[i].d1;     m1_wstrb = tv[i].s1;
      #2;
      chk($sformatf("v%0d m0_gnt", i), 32'(m0_gnt), 32'(tv[i].gnt[0]));
      chk($sformatf("v%0d m1_gnt", i), 32'(m1_gnt), 32'(tv[i].gnt[1]));
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tv[i].rv[0]));
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tv[i].rv[1]));
      chk($sformatf("v%0d m0_rdata", i), m0_rdata, tv[i].q0);
      chk($sformatf("v%0d m1_rdata", i), m1_rdata, tv[i].q1);
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(tv[i].en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tv[i].mwe));
      if (tv[i].en) begin
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].ma));
        chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(tv[i].ms));
      end
      tick();
    end

    // Requester changes its command right after grant: captured values go to the RAM.
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h210; m0_wdata = 32'hCAFE_F00D; m0_wstrb = 4'hF;
    #2 chk("hold gnt", 32'(m0_gnt), 32'd1);
    tick();
    m0_req = 1'b0; m0_addr = 32'h300; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'h0;
    #2;
    chk("hold mem_en", 32'(mem_en), 32'd1);
    chk("hold mem_addr", 32'(mem_addr), 32'd132);
    chk("hold mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("hold mem_wstrb", 32'(mem_wstrb), 32'hF);
    tick();
    #2 chk("hold rvalid", 32'(m0_rvalid), 32'd1);
    tick();
    chk("hold ram captured", ram[132], 32'hCAFE_F00D);
    chk("hold ram other", ram[192], 32'h0);

    // Reset during RESP of a write: no completion, but the write stays in RAM.
    idle_inputs();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h214; m0_wdata = 32'h1111_2222; m0_wstrb = 4'hF;
    #2 chk("abort gnt", 32'(m0_gnt), 32'd1);
    tick();
    idle_inputs();
    #2 chk("abort mem_we", 32'(mem_we), 32'd1);
    tick();
    reset = 1'b0;
    #2 chk("abort rvalid", 32'(m0_rvalid), 32'd0);
    tick();
    reset = 1'b1;
    #2;
    chk("abort mem_en", 32'(mem_en), 32'd0);
    chk("abort ram kept", ram[133], 32'h1111_2222);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
